// File: rtl/decode_issue.sv
// decode_issue -- uDLX decode / issue stage (producer side of the ALU interface).
//
// Accepts one instruction word per cycle, reads both source operands from an
// asynchronous register file, sign-extends the 16-bit immediate and issues a
// registered bundle to execute.
//
// Optional feature macro: DECODE_SCOREBOARD_EN
//   defined   : one pending bit per register; RAW/WAW hazards stall decode.
//   undefined : no scoreboard, never stalls (compiler schedules NOPs).
//
// Handshakes (both sides): a transfer happens on a rising clk edge where
// valid and ready are both 1. A producer holds valid and its payload stable
// until that transfer; ready may depend combinationally on valid.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   inst_in, inst_pc              instruction word and its PC
//   inst_valid / inst_ready       fetch-side handshake
//   rf_rd_addr_a/b                combinational RF read addresses (rs1 / rs2)
//   rf_rd_data_a/b                asynchronous RF read data
//   wb_wr_en, wb_wr_addr          writeback retire; clears the pending bit
//   flush                         branch taken in execute; kills the bundle
//   ex_valid / ex_ready           execute-side handshake
//   ex_data_a/b, ex_store_data    ALU operands and SW store data
//   ex_opcode, ex_function        pass-through instruction fields
//   ex_wr_en, ex_wr_addr          destination register
//   ex_mem_rd, ex_mem_wr          load / store
//   ex_illegal                    unknown opcode
//   ex_pc                         PC of the issued instruction
module decode_issue #(
  parameter int DATA_WIDTH     = 32,
  parameter int OPCODE_WIDTH   = 6,
  parameter int FUNCTION_WIDTH = 6,
  parameter int ADDRESS_WIDTH  = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               inst_in,
  input  logic [DATA_WIDTH-1:0]     inst_pc,
  input  logic                      inst_valid,
  output logic                      inst_ready,
  output logic [ADDRESS_WIDTH-1:0]  rf_rd_addr_a,
  output logic [ADDRESS_WIDTH-1:0]  rf_rd_addr_b,
  input  logic [DATA_WIDTH-1:0]     rf_rd_data_a,
  input  logic [DATA_WIDTH-1:0]     rf_rd_data_b,
  input  logic                      wb_wr_en,
  input  logic [ADDRESS_WIDTH-1:0]  wb_wr_addr,
  input  logic                      flush,
  output logic                      ex_valid,
  input  logic                      ex_ready,
  output logic [DATA_WIDTH-1:0]     ex_data_a,
  output logic [DATA_WIDTH-1:0]     ex_data_b,
  output logic [DATA_WIDTH-1:0]     ex_store_data,
  output logic [OPCODE_WIDTH-1:0]   ex_opcode,
  output logic [FUNCTION_WIDTH-1:0] ex_function,
  output logic                      ex_wr_en,
  output logic [ADDRESS_WIDTH-1:0]  ex_wr_addr,
  output logic                      ex_mem_rd,
  output logic                      ex_mem_wr,
  output logic                      ex_illegal,
  output logic [DATA_WIDTH-1:0]     ex_pc
);

  // uDLX opcode map.
  localparam logic [OPCODE_WIDTH-1:0] OP_RTYPE = OPCODE_WIDTH'('h00);
  localparam logic [OPCODE_WIDTH-1:0] OP_BEQZ  = OPCODE_WIDTH'('h04);
  localparam logic [OPCODE_WIDTH-1:0] OP_BNEZ  = OPCODE_WIDTH'('h05);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADDI  = OPCODE_WIDTH'('h08);
  localparam logic [OPCODE_WIDTH-1:0] OP_SUBI  = OPCODE_WIDTH'('h0A);
  localparam logic [OPCODE_WIDTH-1:0] OP_ANDI  = OPCODE_WIDTH'('h0C);
  localparam logic [OPCODE_WIDTH-1:0] OP_ORI   = OPCODE_WIDTH'('h0D);
  localparam logic [OPCODE_WIDTH-1:0] OP_LW    = OPCODE_WIDTH'('h23);
  localparam logic [OPCODE_WIDTH-1:0] OP_SW    = OPCODE_WIDTH'('h2B);

  // ---------------------------------------------------------------------------
  // Field extraction
  // ---------------------------------------------------------------------------
  logic [OPCODE_WIDTH-1:0]   op;
  logic [FUNCTION_WIDTH-1:0] func;
  logic [ADDRESS_WIDTH-1:0]  rs1;
  logic [ADDRESS_WIDTH-1:0]  rs2;
  logic [ADDRESS_WIDTH-1:0]  rd;
  logic [DATA_WIDTH-1:0]     sext;

  assign op   = inst_in[31 -: OPCODE_WIDTH];
  assign func = inst_in[FUNCTION_WIDTH-1:0];
  assign rs1  = inst_in[21 +: ADDRESS_WIDTH];
  assign rs2  = inst_in[16 +: ADDRESS_WIDTH];
  assign rd   = inst_in[11 +: ADDRESS_WIDTH];
  assign sext = {{(DATA_WIDTH-16){inst_in[15]}}, inst_in[15:0]};

  assign rf_rd_addr_a = rs1;
  assign rf_rd_addr_b = rs2;

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0]    d_a;
  logic [DATA_WIDTH-1:0]    d_b;
  logic [DATA_WIDTH-1:0]    d_store;
  logic [ADDRESS_WIDTH-1:0] d_dest;
  logic                     d_wr_en;
  logic                     d_mem_rd;
  logic                     d_mem_wr;
  logic                     d_illegal;
  logic                     d_use_a;
  logic                     d_use_b;

  always_comb begin
    d_a       = '0;
    d_b       = '0;
    d_store   = '0;
    d_dest    = '0;
    d_mem_rd  = 1'b0;
    d_mem_wr  = 1'b0;
    d_illegal = 1'b0;
    d_use_a   = 1'b0;
    d_use_b   = 1'b0;
    case (op)
      OP_RTYPE: begin
        d_a     = rf_rd_data_a;
        d_b     = rf_rd_data_b;
        d_dest  = rd;
        d_use_a = 1'b1;
        d_use_b = 1'b1;
      end
      OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI: begin
        d_a     = rf_rd_data_a;
        d_b     = sext;
        d_dest  = rs2;
        d_use_a = 1'b1;
      end
      OP_LW: begin
        d_a      = rf_rd_data_a;
        d_b      = sext;
        d_dest   = rs2;
        d_use_a  = 1'b1;
        d_mem_rd = 1'b1;
      end
      OP_SW: begin
        // inst[20:16] names the store source here, not a destination.
        d_a      = rf_rd_data_a;
        d_b      = sext;
        d_store  = rf_rd_data_b;
        d_use_a  = 1'b1;
        d_use_b  = 1'b1;
        d_mem_wr = 1'b1;
      end
      OP_BEQZ, OP_BNEZ: begin
        d_a     = rf_rd_data_a;
        d_b     = sext;
        d_use_a = 1'b1;
      end
      default: d_illegal = 1'b1;
    endcase
  end

  // r0 is hard-wired zero: writes to it are dropped and it is never pending.
  assign d_wr_en = |d_dest;

  // ---------------------------------------------------------------------------
  // Handshake / hazard logic
  // ---------------------------------------------------------------------------
  logic stall;
  logic issue;

  assign inst_ready = ~stall & ~flush & (~ex_valid | ex_ready);
  assign issue      = inst_valid & inst_ready;

`ifdef DECODE_SCOREBOARD_EN
  localparam int NUM_REGS = 1 << ADDRESS_WIDTH;

  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] pending_nxt;

  // Clears are applied before the issue set so a same-register set wins.
  always_comb begin
    pending_nxt = pending;
    if (wb_wr_en) pending_nxt[wb_wr_addr] = 1'b0;
    if (flush && ex_valid && ex_wr_en) pending_nxt[ex_wr_addr] = 1'b0;
    if (issue && d_wr_en) pending_nxt[d_dest] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending <= '0;
    else     pending <= pending_nxt;
  end

  // Registered pending bits only: a writeback in this cycle does not bypass.
  assign stall = inst_valid &
                 ((d_use_a & pending[rs1]) |
                  (d_use_b & pending[rs2]) |
                  (d_wr_en & pending[d_dest]));

  logic unused_shamt;
  assign unused_shamt = ^inst_in[10:6];
`else
  assign stall = 1'b0;

  logic unused_no_sb;
  assign unused_no_sb = ^{wb_wr_en, wb_wr_addr, d_use_a, d_use_b, inst_in[10:6]};
`endif

  // ---------------------------------------------------------------------------
  // Issue bundle register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid      <= 1'b0;
      ex_data_a     <= '0;
      ex_data_b     <= '0;
      ex_store_data <= '0;
      ex_opcode     <= '0;
      ex_function   <= '0;
      ex_wr_en      <= 1'b0;
      ex_wr_addr    <= '0;
      ex_mem_rd     <= 1'b0;
      ex_mem_wr     <= 1'b0;
      ex_illegal    <= 1'b0;
      ex_pc         <= '0;
    end else if (issue) begin
      ex_valid      <= 1'b1;
      ex_data_a     <= d_a;
      ex_data_b     <= d_b;
      ex_store_data <= d_store;
      ex_opcode     <= op;
      ex_function   <= func;
      ex_wr_en      <= d_wr_en;
      ex_wr_addr    <= d_dest;
      ex_mem_rd     <= d_mem_rd;
      ex_mem_wr     <= d_mem_wr;
      ex_illegal    <= d_illegal;
      ex_pc         <= inst_pc;
    end else if (flush || ex_ready) begin
      // Bundle fields are left as-is; only valid drops.
      ex_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_issue.sv
// tb_decode_issue -- self-checking bench for decode_issue.
// Directed vector table, hand-written multi-cycle sequences and a random
// phase checked against a transaction-level model of the stage.
module tb_decode_issue;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQZ  = 6'h04;
  localparam logic [5:0] OP_BNEZ  = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SUBI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

`ifdef DECODE_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] inst_in = '0;
  logic [31:0] inst_pc = '0;
  logic        inst_valid = 1'b0;
  logic        inst_ready;
  logic [4:0]  rf_rd_addr_a, rf_rd_addr_b;
  logic [31:0] rf_rd_data_a, rf_rd_data_b;
  logic        wb_wr_en = 1'b0;
  logic [4:0]  wb_wr_addr = '0;
  logic [31:0] wb_data = '0;
  logic        flush = 1'b0;
  logic        ex_valid;
  logic        ex_ready = 1'b1;
  logic [31:0] ex_data_a, ex_data_b, ex_store_data, ex_pc;
  logic [5:0]  ex_opcode, ex_function;
  logic        ex_wr_en, ex_mem_rd, ex_mem_wr, ex_illegal;
  logic [4:0]  ex_wr_addr;

  logic [31:0] rf [32];
  assign rf_rd_data_a = rf[rf_rd_addr_a];
  assign rf_rd_data_b = rf[rf_rd_addr_b];

  always #5 clk = ~clk;

  decode_issue dut (
    .clk(clk), .rst(rst),
    .inst_in(inst_in), .inst_pc(inst_pc), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .rf_rd_addr_a(rf_rd_addr_a), .rf_rd_addr_b(rf_rd_addr_b),
    .rf_rd_data_a(rf_rd_data_a), .rf_rd_data_b(rf_rd_data_b),
    .wb_wr_en(wb_wr_en), .wb_wr_addr(wb_wr_addr), .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_data_a(ex_data_a), .ex_data_b(ex_data_b), .ex_store_data(ex_store_data),
    .ex_opcode(ex_opcode), .ex_function(ex_function),
    .ex_wr_en(ex_wr_en), .ex_wr_addr(ex_wr_addr),
    .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr), .ex_illegal(ex_illegal), .ex_pc(ex_pc)
  );

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [31:0] a, b, store, pc;
    logic [5:0]  opcode, func;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic        mem_rd, mem_wr, illegal, use_a, use_b;
  } bundle_t;

  int          errors = 0;
  int          checks = 0;
  logic        m_valid = 1'b0;
  bundle_t     m_b = '0;
  logic [31:0] m_pend = '0;
  logic [4:0]  exp_q[$];     // destinations issued and awaiting writeback
  logic        last_iss = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bundle_t decode(input logic [31:0] inst, input logic [31:0] pc);
    bundle_t     d;
    logic [31:0] imm;
    d = '0;
    imm = 32'($signed(inst[15:0]));
    d.pc = pc;
    d.opcode = inst[31:26];
    d.func = inst[5:0];
    case (inst[31:26])
      OP_RTYPE: begin
        d.a = rf[inst[25:21]]; d.b = rf[inst[20:16]];
        d.use_a = 1'b1; d.use_b = 1'b1; d.wr_addr = inst[15:11];
      end
      OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI, OP_LW: begin
        d.a = rf[inst[25:21]]; d.b = imm;
        d.use_a = 1'b1; d.wr_addr = inst[20:16];
        d.mem_rd = (inst[31:26] == OP_LW);
      end
      OP_SW: begin
        d.a = rf[inst[25:21]]; d.b = imm; d.store = rf[inst[20:16]];
        d.use_a = 1'b1; d.use_b = 1'b1; d.mem_wr = 1'b1;
      end
      OP_BEQZ, OP_BNEZ: begin
        d.a = rf[inst[25:21]]; d.b = imm; d.use_a = 1'b1;
      end
      default: d.illegal = 1'b1;
    endcase
    d.wr_en = (d.wr_addr != 5'd0);
    return d;
  endfunction

  function automatic logic model_ready();
    bundle_t d;
    logic    hazard;
    d = decode(inst_in, inst_pc);
    hazard = (d.use_a && m_pend[inst_in[25:21]]) ||
             (d.use_b && m_pend[inst_in[20:16]]) ||
             (d.wr_en && m_pend[d.wr_addr]);
    return !(SB && inst_valid && hazard) && !flush && (!m_valid || ex_ready);
  endfunction

  task automatic check_bundle();
    check("ex_valid", ex_valid, m_valid);
    if (m_valid) begin
      check("ex_pc", ex_pc, m_b.pc);
      check("ex_opcode", ex_opcode, m_b.opcode);
      check("ex_function", ex_function, m_b.func);
      check("ex_wr_en", ex_wr_en, m_b.wr_en);
      check("ex_mem_rd", ex_mem_rd, m_b.mem_rd);
      check("ex_mem_wr", ex_mem_wr, m_b.mem_wr);
      check("ex_illegal", ex_illegal, m_b.illegal);
      if (m_b.wr_en) check("ex_wr_addr", ex_wr_addr, m_b.wr_addr);
      if (!m_b.illegal) begin
        check("ex_data_a", ex_data_a, m_b.a);
        check("ex_data_b", ex_data_b, m_b.b);
      end
      if (m_b.mem_wr) check("ex_store_data", ex_store_data, m_b.store);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks (called at a falling edge with inputs already set)
  // ---------------------------------------------------------------------------
  task automatic tick();
    logic    exp_rdy;
    bundle_t d;
    #1;
    exp_rdy = model_ready();
    check("inst_ready", inst_ready, exp_rdy);
    check("rf_rd_addr_a", rf_rd_addr_a, inst_in[25:21]);
    check("rf_rd_addr_b", rf_rd_addr_b, inst_in[20:16]);
    d = decode(inst_in, inst_pc);
    last_iss = inst_valid && exp_rdy;
    @(posedge clk);
    if (flush && m_valid && m_b.wr_en) begin
      m_pend[m_b.wr_addr] = 1'b0;
      if (exp_q.size() > 0 && exp_q[$] == m_b.wr_addr) void'(exp_q.pop_back());
    end
    if (wb_wr_en) m_pend[wb_wr_addr] = 1'b0;
    if (last_iss) begin
      m_b = d;
      m_valid = 1'b1;
      if (d.wr_en) begin
        m_pend[d.wr_addr] = 1'b1;
        exp_q.push_back(d.wr_addr);
      end
    end else if (flush || ex_ready) begin
      m_valid = 1'b0;
    end
    #1;
    if (wb_wr_en && wb_wr_addr != 5'd0) rf[wb_wr_addr] = wb_data;
    @(negedge clk);
    check_bundle();
  endtask

  // Asserts reset part-way through the low phase, checks the cleared state,
  // holds it across one rising edge and releases it on the next falling edge.
  task automatic apply_reset();
    #2 rst = 1'b1;
    #1;
    m_valid = 1'b0;
    m_pend = '0;
    exp_q.delete();
    check("rst_ex_valid", ex_valid, 1'b0);
    check("rst_ex_data_a", ex_data_a, 32'h0);
    check("rst_ex_data_b", ex_data_b, 32'h0);
    check("rst_ex_store_data", ex_store_data, 32'h0);
    check("rst_ex_opcode", ex_opcode, 6'h0);
    check("rst_ex_function", ex_function, 6'h0);
    check("rst_ex_wr_en", ex_wr_en, 1'b0);
    check("rst_ex_wr_addr", ex_wr_addr, 5'h0);
    check("rst_ex_mem", {ex_mem_rd, ex_mem_wr, ex_illegal}, 3'b000);
    check("rst_ex_pc", ex_pc, 32'h0);
    check("rst_inst_ready", inst_ready, model_ready());
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [5:0] ops [10];
    ops = '{OP_RTYPE, OP_BEQZ, OP_BNEZ, OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI, OP_LW, OP_SW, 6'h3F};
    return {ops[$urandom_range(0, 9)], 5'($urandom_range(0, 5)), 5'($urandom_range(0, 5)),
            5'($urandom_range(0, 5)), 5'($urandom_range(0, 31)), 6'($urandom_range(0, 63))};
  endfunction

  // ---------------------------------------------------------------------------
  // Directed vectors
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [31:0] inst, va, vb, a, b, store;
    logic        chk_ab, wr_en;
    logic [4:0]  wr_addr;
    logic        mem_rd, mem_wr, illegal;
  } tv_t;

  tv_t tv [10];

  initial begin
    tv[0] = '{{6'h08, 5'd1, 5'd2, 16'hFFFC}, 32'd10, 32'd0, 32'd10, 32'hFFFFFFFC, 32'd0,
              1'b1, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0};                          // ADDI r2,r1,-4
    tv[1] = '{{6'h2B, 5'd4, 5'd5, 16'd8}, 32'h100, 32'hAB, 32'h100, 32'd8, 32'hAB,
              1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0};                          // SW r5,8(r4)
    tv[2] = '{{6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20}, 32'd7, 32'd9, 32'd7, 32'd9, 32'd0,
              1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0};                          // ADD r3,r1,r2
    tv[3] = '{{6'h23, 5'd7, 5'd6, 16'hFFFF}, 32'h40, 32'h1234, 32'h40, 32'hFFFFFFFF, 32'd0,
              1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0};                          // LW r6,-1(r7)
    tv[4] = '{{6'h08, 5'd1, 5'd0, 16'd1}, 32'd5, 32'd0, 32'd5, 32'd1, 32'd0,
              1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0};                          // ADDI r0,r1,1
    tv[5] = '{{6'h04, 5'd8, 5'd0, 16'h7FFF}, 32'd0, 32'd0, 32'd0, 32'h7FFF, 32'd0,
              1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0};                          // BEQZ r8
    tv[6] = '{{6'h3F, 5'd1, 5'd2, 16'h1234}, 32'd1, 32'd2, 32'd0, 32'd0, 32'd0,
              1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1};                          // unknown 0x3F
    tv[7] = '{{6'h0D, 5'd10, 5'd9, 16'h8000}, 32'hF0, 32'h77, 32'hF0, 32'hFFFF8000, 32'd0,
              1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0};                          // ORI r9,r10
    tv[8] = '{{6'h0A, 5'd12, 5'd11, 16'd3}, 32'd100, 32'd0, 32'd100, 32'd3, 32'd0,
              1'b1, 1'b1, 5'd11, 1'b0, 1'b0, 1'b0};                         // SUBI r11,r12,3
    tv[9] = '{{6'h00, 5'd1, 5'd2, 5'd0, 5'd0, 6'h20}, 32'd1, 32'd2, 32'd1, 32'd2, 32'd0,
              1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0};                          // ADD r0,r1,r2

    for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? 32'h0 : $urandom;

    @(negedge clk);
    apply_reset();

    // ---- table vectors: one instruction from an empty pipeline each ----
    for (int i = 0; i < 10; i++) begin
      inst_valid = 1'b0;
      apply_reset();
      if (tv[i].inst[25:21] != 5'd0) rf[tv[i].inst[25:21]] = tv[i].va;
      if (tv[i].inst[20:16] != 5'd0) rf[tv[i].inst[20:16]] = tv[i].vb;
      inst_in = tv[i].inst;
      inst_pc = 32'h1000 + 32'(i * 4);
      inst_valid = 1'b1;
      ex_ready = 1'b1;
      tick();
      inst_valid = 1'b0;
      check("tv_valid", ex_valid, 1'b1);
      check("tv_opcode", ex_opcode, tv[i].inst[31:26]);
      check("tv_wr_en", ex_wr_en, tv[i].wr_en);
      check("tv_mem_rd", ex_mem_rd, tv[i].mem_rd);
      check("tv_mem_wr", ex_mem_wr, tv[i].mem_wr);
      check("tv_illegal", ex_illegal, tv[i].illegal);
      if (tv[i].wr_en) check("tv_wr_addr", ex_wr_addr, tv[i].wr_addr);
      if (tv[i].chk_ab) begin
        check("tv_data_a", ex_data_a, tv[i].a);
        check("tv_data_b", ex_data_b, tv[i].b);
      end
      if (tv[i].mem_wr) check("tv_store_data", ex_store_data, tv[i].store);
    end

    // ---- dependent ADD after ADDI r2, writeback of r2 three cycles later ----
    inst_valid = 1'b0;
    apply_reset();
    rf[1] = 32'd10;
    rf[2] = 32'h33;
    inst_in = {6'h08, 5'd1, 5'd2, 16'hFFFC};
    inst_pc = 32'h2000;
    inst_valid = 1'b1;
    ex_ready = 1'b1;
    tick();
    inst_in = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20};
    inst_pc = 32'h2004;
`ifdef DECODE_SCOREBOARD_EN
    for (int k = 1; k <= 3; k++) begin
      if (k == 3) begin
        wb_wr_en = 1'b1;
        wb_wr_addr = 5'd2;
        wb_data = 32'h55;
      end
      #1 check("raw_stall_ready", inst_ready, 1'b0);
      tick();
      check("raw_stall_valid", ex_valid, 1'b0);
    end
    wb_wr_en = 1'b0;
    #1 check("raw_release_ready", inst_ready, 1'b1);
    tick();
    check("raw_issue_valid", ex_valid, 1'b1);
    check("raw_issue_b", ex_data_b, 32'h55);
`else
    #1 check("raw_nosb_ready", inst_ready, 1'b1);
    tick();
    check("raw_issue_valid", ex_valid, 1'b1);
    check("raw_issue_b", ex_data_b, 32'h33);
`endif
    check("raw_issue_a", ex_data_a, 32'd10);
    check("raw_issue_dest", ex_wr_addr, 5'd3);
    inst_valid = 1'b0;

    // ---- write to r0 does not block a following r0 reader ----
    apply_reset();
    rf[1] = 32'd3;
    inst_in = {6'h08, 5'd1, 5'd0, 16'd1};
    inst_valid = 1'b1;
    tick();
    check("r0_wr_en", ex_wr_en, 1'b0);
    inst_in = {6'h00, 5'd0, 5'd0, 5'd4, 5'd0, 6'h20};
    #1 check("r0_ready", inst_ready, 1'b1);
    tick();
    check("r0_add_valid", ex_valid, 1'b1);
    check("r0_add_dest", ex_wr_addr, 5'd4);
    check("r0_add_a", ex_data_a, 32'd0);
    inst_valid = 1'b0;

    // ---- back-pressure for three cycles, then flush ----
    apply_reset();
    rf[1] = 32'h11;
    rf[2] = 32'h22;
    inst_in = {6'h00, 5'd1, 5'd2, 5'd7, 5'd0, 6'h20};
    inst_valid = 1'b1;
    ex_ready = 1'b0;
    tick();
    inst_in = {6'h0D, 5'd1, 5'd9, 16'd5};
    for (int k = 0; k < 3; k++) begin
      #1 check("bp_ready", inst_ready, 1'b0);
      tick();
      check("bp_valid", ex_valid, 1'b1);
      check("bp_dest", ex_wr_addr, 5'd7);
      check("bp_a", ex_data_a, 32'h11);
      check("bp_b", ex_data_b, 32'h22);
    end
    flush = 1'b1;
    #1 check("flush_ready", inst_ready, 1'b0);
    tick();
    flush = 1'b0;
    check("flush_valid", ex_valid, 1'b0);
    inst_in = {6'h00, 5'd7, 5'd0, 5'd8, 5'd0, 6'h20};
    ex_ready = 1'b1;
    #1 check("flush_cleared_ready", inst_ready, 1'b1);
    tick();
    check("flush_next_valid", ex_valid, 1'b1);
    check("flush_next_dest", ex_wr_addr, 5'd8);
    inst_valid = 1'b0;

    // ---- asynchronous reset in the middle of a stall ----
    apply_reset();
    rf[1] = 32'd10;
    inst_in = {6'h08, 5'd1, 5'd2, 16'hFFFC};
    inst_valid = 1'b1;
    ex_ready = 1'b0;
    tick();
    inst_in = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20};
    tick();
    check("mid_valid_before", ex_valid, 1'b1);
    apply_reset();
    check("mid_rst_ready", inst_ready, 1'b1);
    tick();
    check("mid_after_valid", ex_valid, 1'b1);
    check("mid_after_dest", ex_wr_addr, 5'd3);
    inst_valid = 1'b0;
    ex_ready = 1'b1;

    // ---- random traffic against the model ----
    apply_reset();
    last_iss = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (!inst_valid || last_iss) begin
        inst_valid = ($urandom_range(0, 3) != 0);
        inst_in = rand_inst();
        inst_pc = $urandom;
      end
      ex_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 11) == 0);
      wb_wr_en = 1'b0;
      if (exp_q.size() > 0 && $urandom_range(0, 2) == 0) begin
        wb_wr_en = 1'b1;
        wb_wr_addr = exp_q.pop_front();
        wb_data = $urandom;
      end
      tick();
    end
    wb_wr_en = 1'b0;
    flush = 1'b0;
    inst_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
